spi_rd_serializer: RTL and testbench
====================================

Name: spi_rd_serializer

Overview:
Read-direction counterpart of the SPI write path. Takes the byte the RAM returns on a read (tx_data / tx_valid) and shifts it out MSB-first on miso, one bit per shift_en strobe, all in the clk domain. A one-entry holding register decouples RAM read timing from the master's shift pace. It reports busy, end-of-byte and dropped-byte (overrun) status.

Parameters:
DATA_W, 8, width of one read byte.
IDLE_LEVEL, 1'b0, miso level driven when no byte is being shifted.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
tx_data  input  DATA_W  read data from RAM; sampled only when tx_valid=1
tx_valid  input  1  single-cycle strobe: tx_data valid
shift_en  input  1  bit-advance strobe from the SPI clock edge detector; one strobe = one bit
miso  output  1  registered serial data out
busy  output  1  1 while a byte (or parity bit) is on the line
tx_done  output  1  1-cycle pulse after the last bit of a byte completes
overrun  output  1  1-cycle pulse: tx_valid arrived with the holding register full; byte dropped
pending  output  1  holding register occupied

Behaviour:
- Reset (rst=1 at a rising clk edge), including mid-byte:
  - state=IDLE; hold empty; shift register and bit counter cleared.
  - miso=IDLE_LEVEL; busy=0; tx_done=0; overrun=0; pending=0.
  - A partially shifted byte is discarded.
- Holding register:
  - tx_valid=1 with hold empty (or being emptied by a load in the same cycle) -> capture tx_data; pending=1 next cycle.
  - tx_valid=1 with hold full and not being emptied -> hold unchanged; overrun=1 for one cycle.
- States: IDLE, SHIFT (plus PARITY when enabled).
- IDLE:
  - If pending=1: load shift register from hold, clear hold, counter=DATA_W-1, go to SHIFT.
  - miso=MSB of the byte and busy=1 from the next cycle.
  - Latency: tx_valid in cycle N (IDLE, hold empty) -> pending=1 in N+1 -> miso=MSB, busy=1 in N+2.
  - shift_en is ignored in IDLE.
- SHIFT:
  - miso always shows the current shift-register MSB.
  - shift_en=1 and counter!=0: shift left one bit, counter-1.
  - shift_en=0: hold miso and counter unchanged; no timeout.
  - shift_en=1 and counter==0 (last bit consumed): tx_done=1 next cycle, then:
    - pending=1 -> back-to-back reload from hold; miso=next MSB in the following cycle; busy stays 1; no IDLE gap.
    - pending=0 -> IDLE; miso=IDLE_LEVEL; busy=0.
- Simultaneous events:
  - tx_valid in the same cycle as a reload from hold -> new byte is captured, no overrun.
  - tx_valid and rst together -> rst wins.
- Exactly DATA_W shift_en strobes per byte (DATA_W+1 with parity). Extra strobes in IDLE have no effect.
- Outputs are registered; no combinational path from any input to miso.

Optional Feature:
Macro: SPI_RD_PARITY_EN
- Defined:
  - After the last data bit, state PARITY drives miso = odd parity of the loaded byte (XNOR-reduce) for one shift_en period.
  - tx_done fires after the parity bit is consumed.
  - Back-to-back reload rules apply from PARITY.
- Not defined: PARITY state and its logic are absent; tx_done follows the last data bit.

Test Plan:
- Reset then tx_data=8'hA5, tx_valid pulse, shift_en every 4th cycle -> busy=1 two cycles later; miso sequence 1,0,1,0,0,1,0,1; tx_done pulse after 8th strobe; miso=0, busy=0.
- 8'h3C accepted, then 8'hC3 tx_valid while shifting -> pending=1; after 8 strobes tx_done, then immediate reload; miso 1,1,0,0,0,0,1,1 with no IDLE cycle.
- Byte shifting, hold full, third tx_valid (8'hFF) -> overrun=1 one cycle; 8'hFF never appears on miso; pending stays 1.
- rst=1 after 3 strobes of 8'h81 -> next cycle miso=IDLE_LEVEL, busy=0, pending=0; a following 8'h01 transmits cleanly 0,0,0,0,0,0,0,1.
- shift_en held 0 for 20 cycles mid-byte -> miso and busy stable; resumes correctly. shift_en strobes in IDLE -> no output change.
- With SPI_RD_PARITY_EN: 8'h07 -> 0,0,0,0,0,1,1,1 then parity 0; 8'h00 -> eight 0s then parity 1; tx_done after the 9th strobe.

Source files
------------

// File: rtl/spi_rd_if.sv
// Read-path bus between the RAM/SPI front end and spi_rd_serializer.
// Also carries the serializer's FSM state so checkers can bind to it.
interface spi_rd_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              shift_en;
  logic              miso;
  logic              busy;
  logic              tx_done;
  logic              overrun;
  logic              pending;
  logic [1:0]        dbg_state;

  // Handshake: tx_valid is a one-cycle strobe with no ready. A byte offered
  // while the holding register is full and not being drained is dropped,
  // and overrun pulses for one cycle.
  modport master (
    output tx_data, tx_valid, shift_en,
    input  miso, busy, tx_done, overrun, pending, dbg_state
  );

  modport slave (
    input  tx_data, tx_valid, shift_en,
    output miso, busy, tx_done, overrun, pending, dbg_state
  );
endinterface

// File: rtl/spi_rd_serializer.sv
// MSB-first read-byte serializer with a one-entry holding register.
// Define SPI_RD_PARITY_EN to append an odd-parity bit after each byte.
module spi_rd_serializer #(
  parameter int   DATA_W     = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  spi_rd_if.slave  bus
);
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef SPI_RD_PARITY_EN
    ,PARITY = 2'd2
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              miso_q, miso_d;
  logic              busy_q, busy_d;
  logic              tx_done_q, tx_done_d;
  logic              overrun_q, overrun_d;
`ifdef SPI_RD_PARITY_EN
  logic              par_q, par_d;
`endif
  logic              load;
  logic              finish;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    miso_d    = miso_q;
    busy_d    = busy_q;
    tx_done_d = 1'b0;
    overrun_d = 1'b0;
`ifdef SPI_RD_PARITY_EN
    par_d     = par_q;
`endif
    load      = 1'b0;
    finish    = 1'b0;

    case (state_q)
      IDLE: begin
        load = pending_q;
      end
      SHIFT: begin
        if (bus.shift_en) begin
          if (cnt_q != '0) begin
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            miso_d  = shreg_q[DATA_W-2];
            cnt_d   = cnt_q - 1'b1;
          end else begin
`ifdef SPI_RD_PARITY_EN
            state_d = PARITY;
            miso_d  = par_q;
`else
            finish  = 1'b1;
`endif
          end
        end
      end
`ifdef SPI_RD_PARITY_EN
      PARITY: begin
        if (bus.shift_en) finish = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
        miso_d  = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase

    // End of byte: reload straight from hold when possible so busy never drops.
    if (finish) begin
      tx_done_d = 1'b1;
      if (pending_q) begin
        load = 1'b1;
      end else begin
        state_d = IDLE;
        miso_d  = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    end

    if (load) begin
      state_d   = SHIFT;
      shreg_d   = hold_q;
      cnt_d     = CNT_W'(DATA_W - 1);
      miso_d    = hold_q[DATA_W-1];
      busy_d    = 1'b1;
      pending_d = 1'b0;
`ifdef SPI_RD_PARITY_EN
      par_d     = ~^hold_q;
`endif
    end

    // A load in this cycle frees the hold slot for an incoming byte.
    if (bus.tx_valid) begin
      if (!pending_q || load) begin
        hold_d    = bus.tx_data;
        pending_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      pending_q <= 1'b0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      miso_q    <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SPI_RD_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      miso_q    <= miso_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
      overrun_q <= overrun_d;
`ifdef SPI_RD_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign bus.miso      = miso_q;
  assign bus.busy      = busy_q;
  assign bus.tx_done   = tx_done_q;
  assign bus.overrun   = overrun_q;
  assign bus.pending   = pending_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_spi_rd_serializer.sv
// Directed bench for spi_rd_serializer: latency, bit order, reload,
// overrun, reset mid-byte, stalls and optional parity.
module tb_spi_rd_serializer;
`ifdef SPI_RD_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  spi_rd_if #(.DATA_W(8)) bus ();

  spi_rd_serializer #(.DATA_W(8), .IDLE_LEVEL(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    chk("send_pending", {31'b0, bus.pending}, 32'd1);
    chk("send_busy_lat1", {31'b0, bus.busy}, 32'd0);
    tick();
    chk("send_busy_lat2", {31'b0, bus.busy}, 32'd1);
    chk("send_pending_clr", {31'b0, bus.pending}, 32'd0);
  endtask

  // One bit period: check miso, strobe once, then three quiet cycles.
  task automatic strobe_bit(input logic exp_bit, input logic last);
    chk("miso_bit", {31'b0, bus.miso}, {31'b0, exp_bit});
    bus.shift_en = 1'b1;
    tick();
    bus.shift_en = 1'b0;
    chk("tx_done", {31'b0, bus.tx_done}, {31'b0, last});
    tick();
    chk("tx_done_pulse", {31'b0, bus.tx_done}, 32'd0);
    tick();
    tick();
  endtask

  task automatic inject(input logic [7:0] d, input logic exp_ovr);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    chk("inj_overrun", {31'b0, bus.overrun}, {31'b0, exp_ovr});
    chk("inj_pending", {31'b0, bus.pending}, 32'd1);
    tick();
    chk("overrun_pulse", {31'b0, bus.overrun}, 32'd0);
  endtask

  // Shift a whole byte; optionally inject up to two bytes after given bits.
  // After the final strobe, expect either a reload (next MSB) or idle.
  task automatic shift_byte(input logic [7:0] b,
                            input int inj0_at, input logic [7:0] inj0,
                            input int inj1_at, input logic [7:0] inj1,
                            input logic reload, input logic next_msb);
    for (int i = 7; i >= 0; i--) begin
      strobe_bit(b[i], (i == 0) && !PAR);
      if (i == inj0_at) inject(inj0, 1'b0);
      if (i == inj1_at) inject(inj1, 1'b1);
    end
    if (PAR) strobe_bit(~^b, 1'b1);
    chk("end_busy", {31'b0, bus.busy}, {31'b0, reload});
    chk("end_miso", {31'b0, bus.miso}, {31'b0, reload ? next_msb : 1'b0});
    chk("end_pending", {31'b0, bus.pending}, 32'd0);
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.shift_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_miso", {31'b0, bus.miso}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_pending", {31'b0, bus.pending}, 32'd0);
    chk("rst_tx_done", {31'b0, bus.tx_done}, 32'd0);
    chk("rst_overrun", {31'b0, bus.overrun}, 32'd0);

    // single byte A5 -> 1,0,1,0,0,1,0,1 then idle
    send_byte(8'hA5);
    shift_byte(8'hA5, -1, 8'h00, -1, 8'h00, 1'b0, 1'b0);

    // 3C with C3 queued mid-byte -> back-to-back reload, no idle gap
    send_byte(8'h3C);
    shift_byte(8'h3C, 6, 8'hC3, -1, 8'h00, 1'b1, 1'b1);
    shift_byte(8'hC3, -1, 8'h00, -1, 8'h00, 1'b0, 1'b0);

    // overrun: 55 shifting, AA held, FF dropped
    send_byte(8'h55);
    shift_byte(8'h55, 6, 8'hAA, 4, 8'hFF, 1'b1, 1'b1);
    shift_byte(8'hAA, -1, 8'h00, -1, 8'h00, 1'b0, 1'b0);

    // reset after 3 strobes of 81, tx_valid coincident with rst is ignored
    send_byte(8'h81);
    strobe_bit(1'b1, 1'b0);
    strobe_bit(1'b0, 1'b0);
    strobe_bit(1'b0, 1'b0);
    rst          = 1'b1;
    bus.tx_data  = 8'h7E;
    bus.tx_valid = 1'b1;
    tick();
    rst          = 1'b0;
    bus.tx_valid = 1'b0;
    chk("midrst_miso", {31'b0, bus.miso}, 32'd0);
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_pending", {31'b0, bus.pending}, 32'd0);
    send_byte(8'h01);
    shift_byte(8'h01, -1, 8'h00, -1, 8'h00, 1'b0, 1'b0);

    // stall 20 cycles mid-byte on 96 (1,0,0,1,0,1,1,0)
    send_byte(8'h96);
    strobe_bit(1'b1, 1'b0);
    strobe_bit(1'b0, 1'b0);
    strobe_bit(1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("stall_miso", {31'b0, bus.miso}, 32'd1);
      chk("stall_busy", {31'b0, bus.busy}, 32'd1);
    end
    strobe_bit(1'b1, 1'b0);
    strobe_bit(1'b0, 1'b0);
    strobe_bit(1'b1, 1'b0);
    strobe_bit(1'b1, 1'b0);
    strobe_bit(1'b0, !PAR);
    if (PAR) strobe_bit(1'b1, 1'b1);
    chk("stall_end_busy", {31'b0, bus.busy}, 32'd0);

    // strobes in idle do nothing
    bus.shift_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("idle_miso", {31'b0, bus.miso}, 32'd0);
      chk("idle_busy", {31'b0, bus.busy}, 32'd0);
      chk("idle_tx_done", {31'b0, bus.tx_done}, 32'd0);
    end
    bus.shift_en = 1'b0;
    tick();

    // parity vectors (plain bytes when parity is disabled)
    send_byte(8'h07);
    shift_byte(8'h07, -1, 8'h00, -1, 8'h00, 1'b0, 1'b0);
    send_byte(8'h00);
    shift_byte(8'h00, -1, 8'h00, -1, 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
